food_placer: RTL
================

# food_placer

Consumer side of the food-position generator: on each placement request it samples the generator's candidate (row, one-hot column) and tests it against the snake body occupancy map. It commits the first free candidate as the active food cell. After 64 consecutive rejections it falls back to a deterministic linear scan. If no cell is free it flags the board as full. It sits between the position generator and the game/render logic.

## Interface
- ROWS, 8, board rows; row index width 3
- COLS, 8, board columns; column is one-hot, 8 bits
- MAX_TRIES, 64, rejected candidates before fallback scan
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- place_req  in  1  request new food (eat event or game start); level or pulse, accepted only in IDLE
- cand_y  in  3  candidate row from generator
- cand_x  in  8  candidate column, one-hot, bit c = column c
- body_map  in  64  occupancy, bit (y*8+c) = 1 when cell occupied by snake
- food_y  out  3  committed food row
- food_x  out  8  committed food column, one-hot
- food_valid  out  1  food_y/food_x hold a live food cell
- place_done  out  1  one-cycle pulse on commit
- busy  out  1  high in every state except IDLE and FULL
- board_full  out  1  no free cell found; sticky until reset

## Operation
- Reset (reset=0 at an edge): state IDLE, food_y=3'b011, food_x=8'b01000000, food_valid=0, place_done=0, busy=0, board_full=0, try counter and scan index = 0. Reset mid-operation aborts any search; outputs take reset values at that edge.
- States: IDLE, SAMPLE, CHECK, SCAN, FULL.
- IDLE: place_req=1 -> SAMPLE, food_valid<=0, try counter<=0.
- SAMPLE: register cand_y/cand_x into cand_q -> CHECK.
- CHECK: decode cand_x_q to column c. Candidate is free when cand_x_q is exactly one-hot and body_map[cand_y_q*8+c]==0.
  - Free: commit food_y/food_x<=cand_q, food_valid<=1, place_done<=1, -> IDLE.
  - Otherwise: try counter+1. If the new count equals MAX_TRIES, go to SCAN with scan index 0. Else go to SAMPLE.
- SCAN: test body_map[idx], one cell per cycle.
  - Free: commit food_y=idx[5:3], food_x=1<<idx[2:0], place_done<=1, -> IDLE.
  - Occupied and idx==63: board_full<=1, -> FULL.
  - Else: idx+1.
- FULL: absorbing until reset. food_valid=0 and place_req is ignored.
- body_map is read live in the CHECK/SCAN cycle. It is not snapshotted at request time.
- place_req is ignored in all states except IDLE. It re-triggers only from IDLE, so a level held high after place_done starts a new placement on the next cycle.
- Width rules: cell index 6 bits and wraps never (SCAN terminates at 63). Try counter is 7 bits so that it can reach 64.

## Timing
- Best case: place_req sampled at edge N. SAMPLE occupies N..N+1, CHECK occupies N+1..N+2. Commit at edge N+2: food_valid and place_done are high in cycle N+2..N+3.
- Each rejected candidate costs 2 cycles.
- Fallback worst case is 128 cycles of rejections plus up to 64 scan cycles.
- place_done is exactly one cycle wide and registered.
- The generator advances every clock independently. Successive SAMPLE cycles see different candidates, and no handshake to the generator exists.

## Structure
- Shared package snake_pkg holds:
  - ROWS, COLS, MAX_TRIES constants
  - the cell-index function (y*8+c)
  - the state encoding IDLE/SAMPLE/CHECK/SCAN/FULL
  - reset food position 3'b011 / 8'b01000000
- Sub-module col_encoder: one-hot 8 -> binary 3 plus an onehot_ok flag. onehot_ok=0 for all-zero inputs or multi-bit inputs.

## Test plan
- Reset: hold reset=0 one edge -> food_y=3, food_x=0x40, food_valid=0, busy=0, board_full=0, place_done=0.
- Empty body_map, place_req pulse with cand=(2,0x20) -> 2 cycles later food_y=2, food_x=0x20, food_valid=1, one-cycle place_done.
- body_map bit 21 set (cell 2,5), cand=(2,0x20) then (5,0x08) -> first candidate rejected, food=(5,0x08) committed 4 cycles after request.
- cand_x=0x00 then 0x03 then (1,0x01) on empty map -> both malformed values rejected, food=(1,0x01) after 6 cycles.
- body_map all ones except bit 63, generator never yields (7,0x80) -> 64 rejections, SCAN commits food=(7,0x80) at 128+64 cycles. busy stays high throughout.
- body_map all ones -> board_full=1 after 192 cycles, food_valid=0, later place_req ignored. Additionally, assert reset=0 mid-SAMPLE/CHECK in a separate run -> returns to IDLE with reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: board geometry, placer state encoding,
// reset food position and the cell-index helper.
package snake_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int MAX_TRIES = 64;

  localparam logic [2:0] RESET_FOOD_Y = 3'b011;
  localparam logic [7:0] RESET_FOOD_X = 8'b0100_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CHECK,
    ST_SCAN,
    ST_FULL
  } placer_state_t;

  // Row-major cell index y*8+c.
  function automatic logic [5:0] cell_index(input logic [2:0] y, input logic [2:0] c);
    return {y, c};
  endfunction

endpackage

// File: rtl/col_encoder.sv
// One-hot column to binary index; onehot_ok is low for zero or multi-bit inputs.
module col_encoder
  import snake_pkg::*;
(
  input  logic [COLS-1:0] col_onehot,
  output logic [2:0]      col_bin,
  output logic            onehot_ok
);

  always_comb begin
    col_bin = 3'd0;
    for (int i = 0; i < COLS; i++) begin
      if (col_onehot[i]) col_bin = 3'(i);
    end
  end

  assign onehot_ok = (col_onehot != '0) && ((col_onehot & (col_onehot - 8'd1)) == '0);

endmodule

// File: rtl/food_placer.sv
// Food placement: tries generator candidates against the snake body, falls
// back to a linear scan after MAX_TRIES rejections, flags a full board.
module food_placer
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        place_req,
  input  logic [2:0]  cand_y,
  input  logic [7:0]  cand_x,
  input  logic [63:0] body_map,
  output logic [2:0]  food_y,
  output logic [7:0]  food_x,
  output logic        food_valid,
  output logic        place_done,
  output logic        busy,
  output logic        board_full
);

  placer_state_t state, state_d;

  logic [2:0] cand_y_q, cand_y_d;
  logic [7:0] cand_x_q, cand_x_d;
  logic [6:0] try_cnt, try_cnt_d;
  logic [5:0] scan_idx, scan_idx_d;
  logic [2:0] food_y_d;
  logic [7:0] food_x_d;
  logic       food_valid_d, place_done_d, board_full_d;

  logic [2:0] cand_col;
  logic       cand_ok;

  col_encoder u_col_encoder (
    .col_onehot (cand_x_q),
    .col_bin    (cand_col),
    .onehot_ok  (cand_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cand_y_q   <= '0;
      cand_x_q   <= '0;
      try_cnt    <= '0;
      scan_idx   <= '0;
      food_y     <= RESET_FOOD_Y;
      food_x     <= RESET_FOOD_X;
      food_valid <= 1'b0;
      place_done <= 1'b0;
      board_full <= 1'b0;
    end else begin
      state      <= state_d;
      cand_y_q   <= cand_y_d;
      cand_x_q   <= cand_x_d;
      try_cnt    <= try_cnt_d;
      scan_idx   <= scan_idx_d;
      food_y     <= food_y_d;
      food_x     <= food_x_d;
      food_valid <= food_valid_d;
      place_done <= place_done_d;
      board_full <= board_full_d;
    end
  end

  always_comb begin
    state_d      = state;
    cand_y_d     = cand_y_q;
    cand_x_d     = cand_x_q;
    try_cnt_d    = try_cnt;
    scan_idx_d   = scan_idx;
    food_y_d     = food_y;
    food_x_d     = food_x;
    food_valid_d = food_valid;
    place_done_d = 1'b0;
    board_full_d = board_full;

    case (state)
      ST_IDLE: begin
        if (place_req) begin
          state_d      = ST_SAMPLE;
          food_valid_d = 1'b0;
          try_cnt_d    = '0;
        end
      end
      ST_SAMPLE: begin
        cand_y_d = cand_y;
        cand_x_d = cand_x;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        // body_map is read live here, so a cell vacated mid-search is usable.
        if (cand_ok && !body_map[cell_index(cand_y_q, cand_col)]) begin
          food_y_d     = cand_y_q;
          food_x_d     = cand_x_q;
          food_valid_d = 1'b1;
          place_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          try_cnt_d = try_cnt + 7'd1;
          if (try_cnt_d == 7'(MAX_TRIES)) begin
            scan_idx_d = '0;
            state_d    = ST_SCAN;
          end else begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SCAN: begin
        if (!body_map[scan_idx]) begin
          food_y_d     = scan_idx[5:3];
          food_x_d     = 8'd1 << scan_idx[2:0];
          food_valid_d = 1'b1;
          place_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (scan_idx == 6'd63) begin
          board_full_d = 1'b1;
          state_d      = ST_FULL;
        end else begin
          scan_idx_d = scan_idx + 6'd1;
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_SAMPLE) || (state == ST_CHECK) || (state == ST_SCAN);

endmodule
